// File: rtl/noc_shim_pkg.sv
// noc_shim_pkg: sizing helpers and beat buffer control type
// shared by the AXIS-to-flit serializer shim and its arbiter.
package noc_shim_pkg;

   function automatic int flit_width(input int tdata_w, input int sf);
      return tdata_w / sf;
   endfunction

   function automatic int chan_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int dest_width(input int n, input int tdest_w);
      return chan_width(n) + tdest_w;
   endfunction

   typedef struct packed {
      logic valid;
      logic last;
   } beat_buf_t;

endpackage

// File: rtl/axis_flit_serializer_mc_if.sv
// axis_flit_serializer_mc_if: bundle of NUM_CHANNELS AXIS
// source channels feeding the flit serializer.
interface axis_flit_serializer_mc_if #(
   parameter int NUM_CHANNELS = 2,
   parameter int TDEST_WIDTH  = 6,
   parameter int TDATA_WIDTH  = 512
);
   logic                   axis_in_tvalid [NUM_CHANNELS];
   logic                   axis_in_tready [NUM_CHANNELS];
   logic [TDATA_WIDTH-1:0] axis_in_tdata  [NUM_CHANNELS];
   logic                   axis_in_tlast  [NUM_CHANNELS];
   logic [TDEST_WIDTH-1:0] axis_in_tdest  [NUM_CHANNELS];

   modport master (
      output axis_in_tvalid, axis_in_tdata,
      output axis_in_tlast, axis_in_tdest,
      input  axis_in_tready
   );

   modport slave (
      input  axis_in_tvalid, axis_in_tdata,
      input  axis_in_tlast, axis_in_tdest,
      output axis_in_tready
   );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester at or
// after the pointer; pointer moves past the winner on advance.
module rr_arbiter
   import noc_shim_pkg::*;
#(
   parameter int N = 2,
   localparam int W = chan_width(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx
);
   logic [W-1:0] ptr;
   int           best;
   int           d;

   // nearest requester measured as distance from the pointer
   always_comb begin
      best      = N;
      d         = 0;
      grant_idx = '0;
      grant     = '0;
      for (int j = 0; j < N; j++) begin
         d = j - int'(ptr);
         if (d < 0) d = d + N;
         if (req[j] && d < best) begin
            best      = d;
            grant_idx = W'(j);
         end
      end
      for (int j = 0; j < N; j++) begin
         grant[j] = (best < N) && (grant_idx == W'(j));
      end
   end

   // pointer becomes winner + 1 on each accepted grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_idx == W'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end
endmodule

// File: rtl/axis_flit_serializer_mc.sv
// axis_flit_serializer_mc: packet-granular round-robin over AXIS
// channels, each beat split into flits under credit flow control.
module axis_flit_serializer_mc
   import noc_shim_pkg::*;
#(
   parameter int NUM_CHANNELS         = 2,
   parameter int TDEST_WIDTH          = 6,
   parameter int TDATA_WIDTH          = 512,
   parameter int SERIALIZATION_FACTOR = 4,
   parameter int FLIT_BUFFER_DEPTH    = 4,
   localparam int FLIT_WIDTH =
      flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR),
   localparam int CHAN_W = chan_width(NUM_CHANNELS),
   localparam int DEST_WIDTH =
      dest_width(NUM_CHANNELS, TDEST_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   axis_flit_serializer_mc_if.slave axis,
   output logic [FLIT_WIDTH-1:0] data_out,
   output logic [DEST_WIDTH-1:0] dest_out,
   output logic                  is_tail_out,
   output logic                  send_out,
   input  logic                  credit_in
);
   localparam int KW = (SERIALIZATION_FACTOR <= 1) ? 1 :
                       $clog2(SERIALIZATION_FACTOR);
   localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam logic [KW-1:0] K_LAST =
      KW'(SERIALIZATION_FACTOR - 1);
   localparam logic [CW-1:0] C_MAX = CW'(FLIT_BUFFER_DEPTH);

   if ((SERIALIZATION_FACTOR < 1) || (NUM_CHANNELS < 1) ||
       (TDATA_WIDTH % SERIALIZATION_FACTOR != 0))
   begin : g_bad_cfg
      $error("TDATA_WIDTH must split evenly into flits");
   end

   beat_buf_t               bbuf;
   logic [TDATA_WIDTH-1:0]  bdata;
   logic [DEST_WIDTH-1:0]   bdest;
   logic [KW-1:0]           k;
   logic [CW-1:0]           credits;
   logic                    locked;
   logic [CHAN_W-1:0]       lock_ch;
   logic [NUM_CHANNELS-1:0] req;
   logic [NUM_CHANNELS-1:0] grant;
   logic [NUM_CHANNELS-1:0] ready;
   logic [CHAN_W-1:0]       grant_idx;
   logic [CHAN_W-1:0]       acc_idx;
   logic                    send;
   logic                    final_flit;
   logic                    room;
   logic                    accept;
   logic                    advance;
   logic [TDATA_WIDTH-1:0]  in_data;
   logic                    in_last;
   logic [TDEST_WIDTH-1:0]  in_dest;
   logic [FLIT_WIDTH-1:0]   flit;

   // send whenever a beat is held and downstream has space
   always_comb begin
      send       = bbuf.valid && (credits != '0);
      final_flit = send && (k == K_LAST);
      room       = !bbuf.valid || final_flit;
   end

   // gather per-channel valids for the arbiter
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         req[i] = axis.axis_in_tvalid[i];
      end
   end

   rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .advance   (advance),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // locked channel overrides arbitration; mux the chosen beat
   always_comb begin
      ready   = '0;
      in_data = '0;
      in_last = 1'b0;
      in_dest = '0;
      acc_idx = locked ? lock_ch : grant_idx;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         ready[i] = rst_n && room &&
                    (locked ? (lock_ch == CHAN_W'(i)) : grant[i]);
         if (acc_idx == CHAN_W'(i)) begin
            in_data = axis.axis_in_tdata[i];
            in_last = axis.axis_in_tlast[i];
            in_dest = axis.axis_in_tdest[i];
         end
      end
      accept  = |(ready & req);
      advance = accept && !locked;
   end

   // drive the per-channel ready lines
   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         axis.axis_in_tready[i] = ready[i];
      end
   end

   // select flit k of the held beat, LSB first
   always_comb begin
      flit = '0;
      for (int j = 0; j < SERIALIZATION_FACTOR; j++) begin
         if (k == KW'(j)) flit = bdata[j*FLIT_WIDTH +: FLIT_WIDTH];
      end
   end

   // beat buffer, flit index and packet lock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bbuf    <= '0;
         bdata   <= '0;
         bdest   <= '0;
         k       <= '0;
         locked  <= 1'b0;
         lock_ch <= '0;
      end else begin
         if (send) k <= final_flit ? '0 : k + 1'b1;
         if (accept) begin
            bbuf.valid <= 1'b1;
            bbuf.last  <= in_last;
            bdata      <= in_data;
            bdest      <= {acc_idx, in_dest};
            locked     <= !in_last;
            lock_ch    <= acc_idx;
         end else if (final_flit) begin
            bbuf.valid <= 1'b0;
         end
      end
   end

   // credit count; a surplus credit at full is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits <= C_MAX;
      end else if (credit_in && !send) begin
         if (credits != C_MAX) credits <= credits + 1'b1;
      end else if (!credit_in && send) begin
         credits <= credits - 1'b1;
      end
   end

   // registered flit outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         send_out    <= 1'b0;
         is_tail_out <= 1'b0;
         data_out    <= '0;
         dest_out    <= '0;
      end else begin
         send_out    <= send;
         is_tail_out <= final_flit && bbuf.last;
         if (send) begin
            data_out <= flit;
            dest_out <= bdest;
         end
      end
   end
endmodule

// File: tb/tb_axis_flit_serializer_mc.sv
// tb_axis_flit_serializer_mc: directed vectors for the shim,
// main instance 2ch/4 flits, second instance 1ch/1 flit.
module tb_axis_flit_serializer_mc;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axis_flit_serializer_mc_if #(
      .NUM_CHANNELS(2), .TDEST_WIDTH(6), .TDATA_WIDTH(64)
   ) ifc ();
   axis_flit_serializer_mc_if #(
      .NUM_CHANNELS(1), .TDEST_WIDTH(6), .TDATA_WIDTH(16)
   ) ifc1 ();

   logic [15:0] data_out;
   logic [6:0]  dest_out;
   logic        is_tail_out;
   logic        send_out;
   logic        credit_in;
   logic [15:0] data1;
   logic [6:0]  dest1;
   logic        tail1;
   logic        send1;
   logic        credit1;

   axis_flit_serializer_mc #(
      .NUM_CHANNELS(2), .TDEST_WIDTH(6), .TDATA_WIDTH(64),
      .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .axis(ifc),
      .data_out(data_out), .dest_out(dest_out),
      .is_tail_out(is_tail_out), .send_out(send_out),
      .credit_in(credit_in)
   );

   axis_flit_serializer_mc #(
      .NUM_CHANNELS(1), .TDEST_WIDTH(6), .TDATA_WIDTH(16),
      .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(4)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .axis(ifc1),
      .data_out(data1), .dest_out(dest1),
      .is_tail_out(tail1), .send_out(send1),
      .credit_in(credit1)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [15:0] q_data [$];
   logic [6:0]  q_dest [$];
   logic        q_tail [$];
   int          q_cyc  [$];
   logic [15:0] q1_data [$];
   logic        q1_tail [$];
   logic [6:0]  q1_dest [$];
   int          q1_cyc  [$];
   logic [7:0]  dl = '0;
   int          cdelay = 0;
   logic        cred_en = 1'b0;
   logic        auto_cred = 1'b0;
   logic        man_cred = 1'b0;

   assign credit_in = auto_cred | man_cred;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rst_n && credit_in)
         assert (dut.credits != 3'd4)
         else $error("FAIL credit_ovf credit returned at full count");
   end

   always @(negedge clk) begin
      if (send_out) begin
         q_data.push_back(data_out);
         q_dest.push_back(dest_out);
         q_tail.push_back(is_tail_out);
         q_cyc.push_back(cyc);
      end
      if (send1) begin
         q1_data.push_back(data1);
         q1_dest.push_back(dest1);
         q1_tail.push_back(tail1);
         q1_cyc.push_back(cyc);
      end
      if (!rst_n) begin
         dl = '0;
         auto_cred = 1'b0;
         credit1 = 1'b0;
      end else begin
         dl = {dl[6:0], send_out};
         auto_cred = cred_en && dl[cdelay];
         credit1 = send1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] fv(int ch, int b, int k);
      return 16'(32'hC000 + ch * 256 + b * 16 + k);
   endfunction

   function automatic logic [63:0] beat(int ch, int b);
      return {fv(ch, b, 3), fv(ch, b, 2), fv(ch, b, 1), fv(ch, b, 0)};
   endfunction

   task automatic drive_pkt(input int ch, input int nb,
                            input logic [5:0] td, input int gap_at);
      for (int b = 0; b < nb; b++) begin
         int t;
         if (b == gap_at) begin
            ifc.axis_in_tvalid[ch] = 1'b0;
            repeat (4) @(negedge clk);
         end
         ifc.axis_in_tvalid[ch] = 1'b1;
         ifc.axis_in_tdata[ch]  = beat(ch, b);
         ifc.axis_in_tlast[ch]  = (b == nb - 1);
         ifc.axis_in_tdest[ch]  = td;
         t = 0;
         #1;
         while (!ifc.axis_in_tready[ch] && t < 300) begin
            @(negedge clk);
            #1;
            t++;
         end
         if (t >= 300) chk("hs_timeout", 64'(t), 0);
         @(negedge clk);
      end
      ifc.axis_in_tvalid[ch] = 1'b0;
   endtask

   task automatic wait_flits(input int base, input int n);
      int t = 0;
      while (q_data.size() - base < n && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      repeat (4) @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base;
      int n;
      for (int i = 0; i < 2; i++) begin
         ifc.axis_in_tvalid[i] = 1'b0;
         ifc.axis_in_tdata[i]  = '0;
         ifc.axis_in_tlast[i]  = 1'b0;
         ifc.axis_in_tdest[i]  = '0;
      end
      ifc1.axis_in_tvalid[0] = 1'b0;
      ifc1.axis_in_tdata[0]  = '0;
      ifc1.axis_in_tlast[0]  = 1'b0;
      ifc1.axis_in_tdest[0]  = '0;

      // reset state, with a valid source held during reset
      ifc.axis_in_tvalid[0] = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_send", 64'(send_out), 0);
      chk("rst_tail", 64'(is_tail_out), 0);
      chk("rst_data", 64'(data_out), 0);
      chk("rst_dest", 64'(dest_out), 0);
      chk("rst_rdy0", 64'(ifc.axis_in_tready[0]), 0);
      chk("rst_rdy1", 64'(ifc.axis_in_tready[1]), 0);
      chk("rst_cred", 64'(dut.credits), 4);
      ifc.axis_in_tvalid[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // single 2-beat packet, slow credit return
      cred_en = 1'b1;
      cdelay = 3;
      @(negedge clk);
      base = q_data.size();
      drive_pkt(0, 2, 6'h15, -1);
      wait_flits(base, 8);
      n = q_data.size() - base;
      chk("t1_cnt", 64'(n), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < n) begin
            chk("t1_data", 64'(q_data[base+i]), 64'(fv(0, i / 4, i % 4)));
            chk("t1_tail", 64'(q_tail[base+i]), 64'(i == 7));
            chk("t1_dest", 64'(q_dest[base+i]), 64'h15);
         end
      end
      if (n >= 8) begin
         chk("t1_stall", 64'(q_cyc[base+4] - q_cyc[base+3]), 2);
         chk("t1_resume", 64'(q_cyc[base+7] - q_cyc[base+4]), 3);
      end
      repeat (20) @(negedge clk);

      // two competing 3-beat packets, fast credit return
      do_reset();
      cdelay = 0;
      @(negedge clk);
      base = q_data.size();
      fork
         drive_pkt(0, 3, 6'h0A, -1);
         drive_pkt(1, 3, 6'h2B, -1);
      join
      wait_flits(base, 24);
      n = q_data.size() - base;
      chk("t2_cnt", 64'(n), 24);
      for (int i = 0; i < 24; i++) begin
         if (i < n) begin
            chk("t2_data", 64'(q_data[base+i]),
                64'(fv(i / 12, (i % 12) / 4, i % 4)));
            chk("t2_tail", 64'(q_tail[base+i]), 64'(i % 12 == 11));
            chk("t2_dest", 64'(q_dest[base+i]),
                (i < 12) ? 64'h0A : 64'h6B);
         end
      end
      if (n >= 24) chk("t2_nogap", 64'(q_cyc[base+23] - q_cyc[base]), 23);

      // pointer back at 0: channel 0 wins a tie again
      base = q_data.size();
      fork
         drive_pkt(1, 1, 6'h01, -1);
         drive_pkt(0, 1, 6'h02, -1);
      join
      wait_flits(base, 8);
      n = q_data.size() - base;
      chk("ptr_cnt", 64'(n), 8);
      if (n >= 8) begin
         chk("ptr_first", 64'(q_dest[base]), 64'h02);
         chk("ptr_second", 64'(q_dest[base+4]), 64'h41);
      end

      // channel 1 stalls mid-packet yet keeps the lock
      base = q_data.size();
      fork
         drive_pkt(1, 3, 6'h33, 1);
         begin
            repeat (2) @(negedge clk);
            drive_pkt(0, 1, 6'h04, -1);
         end
      join
      wait_flits(base, 16);
      n = q_data.size() - base;
      chk("t3_cnt", 64'(n), 16);
      if (n >= 16) begin
         for (int i = 0; i < 12; i++)
            chk("t3_dest1", 64'(q_dest[base+i]), 64'h73);
         chk("t3_tail1", 64'(q_tail[base+11]), 1);
         chk("t3_dest0", 64'(q_dest[base+12]), 64'h04);
         chk("t3_data0", 64'(q_data[base+12]), 64'(fv(0, 0, 0)));
      end

      // credits exhausted, then credit and send coincide at 1
      repeat (5) @(negedge clk);
      cred_en = 1'b0;
      base = q_data.size();
      drive_pkt(0, 2, 6'h11, -1);
      repeat (10) @(negedge clk);
      #1;
      chk("t4_hold_cnt", 64'(q_data.size() - base), 4);
      chk("t4_cred0", 64'(dut.credits), 0);
      @(negedge clk);
      man_cred = 1'b1;
      repeat (3) @(negedge clk);
      man_cred = 1'b0;
      #1;
      chk("t4_cred1", 64'(dut.credits), 1);
      chk("t4_coinc", 64'(send_out), 1);
      @(negedge clk);
      #1;
      chk("t4_cred_end", 64'(dut.credits), 0);
      chk("t4_cnt7", 64'(q_data.size() - base), 7);
      repeat (5) @(negedge clk);
      #1;
      chk("t4_nosend0", 64'(q_data.size() - base), 7);

      // reset while flit 2 of a beat is on the wire
      do_reset();
      cred_en = 1'b1;
      cdelay = 0;
      @(negedge clk);
      base = q_data.size();
      drive_pkt(0, 1, 6'h05, -1);
      begin
         int t = 0;
         while (q_data.size() - base < 3 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
         end
      end
      chk("t5_mid", 64'(q_data.size() - base), 3);
      rst_n = 1'b0;
      #1;
      chk("t5_send", 64'(send_out), 0);
      chk("t5_data", 64'(data_out), 0);
      chk("t5_dest", 64'(dest_out), 0);
      chk("t5_tail", 64'(is_tail_out), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t5_cred", 64'(dut.credits), 4);
      @(negedge clk);
      base = q_data.size();
      drive_pkt(1, 1, 6'h06, -1);
      wait_flits(base, 4);
      n = q_data.size() - base;
      chk("t5_cnt", 64'(n), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < n) begin
            chk("t5_ndata", 64'(q_data[base+i]), 64'(fv(1, 0, i)));
            chk("t5_ndest", 64'(q_dest[base+i]), 64'h46);
            chk("t5_ntail", 64'(q_tail[base+i]), 64'(i == 3));
         end
      end

      // one flit per beat, back-to-back single-beat packets
      @(negedge clk);
      for (int b = 0; b < 6; b++) begin
         int t = 0;
         ifc1.axis_in_tvalid[0] = 1'b1;
         ifc1.axis_in_tdata[0]  = 16'(32'hA000 + b);
         ifc1.axis_in_tlast[0]  = 1'b1;
         ifc1.axis_in_tdest[0]  = 6'h09;
         #1;
         while (!ifc1.axis_in_tready[0] && t < 100) begin
            @(negedge clk);
            #1;
            t++;
         end
         if (t >= 100) chk("t6_hs_timeout", 64'(t), 0);
         @(negedge clk);
      end
      ifc1.axis_in_tvalid[0] = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      n = q1_data.size();
      chk("t6_cnt", 64'(n), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < n) begin
            chk("t6_data", 64'(q1_data[i]), 64'(32'hA000 + i));
            chk("t6_tail", 64'(q1_tail[i]), 1);
            chk("t6_dest", 64'(q1_dest[i]), 64'h09);
         end
      end
      if (n >= 6) chk("t6_rate", 64'(q1_cyc[5] - q1_cyc[0]), 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axis_flit_serializer_mc.md
# axis_flit_serializer_mc

Single-clock, multi-channel AXI-Stream ingress shim. It accepts packets from NUM_CHANNELS independent AXIS sources and arbitrates between them round-robin at packet granularity. Each granted beat is serialized into SERIALIZATION_FACTOR flits, which it drives into one router injection port under credit-based flow control. It generalises the single-source serializer shim and removes the clock crossing; its flit-side interface is the one the ring and mesh routers already use.

## Interface
- NUM_CHANNELS, default 2: number of AXIS input channels, ≥1.
- TDEST_WIDTH, default 6: AXIS TDEST width.
- TDATA_WIDTH, default 512: AXIS TDATA width; must divide evenly by SERIALIZATION_FACTOR (elaboration error otherwise).
- SERIALIZATION_FACTOR, default 4: flits per beat, ≥1.
- FLIT_BUFFER_DEPTH, default 4: downstream input buffer depth; the initial credit count.
- Derived: FLIT_WIDTH = TDATA_WIDTH/SERIALIZATION_FACTOR; CHAN_W = max(1, clog2(NUM_CHANNELS)); DEST_WIDTH = CHAN_W + TDEST_WIDTH.

Ports:
- clk, in, 1: single clock for all logic.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- axis_in_tvalid, in, 1 [NUM_CHANNELS]: beat valid.
- axis_in_tready, out, 1 [NUM_CHANNELS]: beat accepted.
- axis_in_tdata, in, TDATA_WIDTH [NUM_CHANNELS]: beat payload.
- axis_in_tlast, in, 1 [NUM_CHANNELS]: last beat of packet.
- axis_in_tdest, in, TDEST_WIDTH [NUM_CHANNELS]: destination.
- data_out, out, FLIT_WIDTH: flit payload.
- dest_out, out, DEST_WIDTH: {channel index, tdest}.
- is_tail_out, out, 1: last flit of packet.
- send_out, out, 1: flit valid, one flit per cycle.
- credit_in, in, 1: one-cycle pulse returning one credit.

## Operation
- State: unlocked/locked(ch), beat buffer (valid, data, last, dest, ch), flit index 0..SERIALIZATION_FACTOR-1, credit counter (clog2(FLIT_BUFFER_DEPTH+1) bits), round-robin pointer.
- Arbitration happens only when unlocked. Winner = first channel with tvalid at or after the pointer, wrapping. On acceptance the pointer becomes winner+1 mod NUM_CHANNELS.
- Accepting a non-last beat locks onto that channel. Accepting a tlast beat leaves the block unlocked after that beat.
- axis_in_tready[i] = (buffer empty OR final flit of the buffered beat sends this cycle) AND (i is the locked channel, or no lock is held and i is the arbitration winner). At most one tready is high. tready may depend combinationally on tvalid.
- A flit sends when the buffer is valid and credits > 0. Flits go out LSB first: flit k = tdata[k*FLIT_WIDTH +: FLIT_WIDTH].
- is_tail_out = buffered last AND k = SERIALIZATION_FACTOR-1.
- dest_out is identical on every flit of a packet.
- Credits: −1 per sent flit, +1 per credit_in, net 0 when both occur in one cycle. At 0, sending stalls and the flit index holds. A credit_in when the counter is at FLIT_BUFFER_DEPTH is a protocol violation: the bench asserts on it, and the counter saturates.
- A channel whose tvalid drops mid-packet keeps the lock. Other channels wait.
- Reset mid-packet discards the buffered beat and the lock. Downstream must be reset together with this block.

## Timing
- Reset values: send_out=0, is_tail_out=0, data_out=0, dest_out=0, all tready=0, credits=FLIT_BUFFER_DEPTH, pointer=0, unlocked, buffer empty.
- data_out, dest_out, is_tail_out and send_out are registered.
- Beat accepted at edge E: flit 0 is visible (send_out=1) in the cycle after edge E+1, given credits.
- Steady state is one flit per cycle. The next beat is accepted on the edge that launches the current beat's final flit, so there are no bubbles between beats or between packets of different channels.
- Credit returned at edge E is usable for the send decision at edge E+1.

## Structure
- Package noc_shim_pkg: flit_width() and chan_width() functions, DEST_WIDTH computation, and a beat_buf_t struct.
- Sub-module rr_arbiter (parameter N; inputs req[N], advance; outputs grant one-hot and grant_idx; holds the pointer) is instantiated once.
- Credit counter and serializer stay inline.

## Test plan
- Single channel, FLIT_BUFFER_DEPTH=4, one 2-beat packet, credits returned 3 cycles after each send -> 8 flits; send pattern 4 on, stall, then resumes. is_tail only on flit 8. dest_out={0,tdest} throughout.
- Channels 0 and 1 both valid with 3-beat packets -> packet 0 fully sent (12 flits), then packet 1 with no gap cycle. Pointer=0 after both.
- Channel 1 tvalid gaps mid-packet while channel 0 is valid -> channel 0 gets no tready until channel 1's tlast beat is accepted.
- Credits held at 0 for 10 cycles with credit_in and a send coinciding at count 1 -> count stays 1 and send_out never fires at count 0.
- rst_n asserted mid-beat (flit 2 of 4) -> outputs 0 immediately. After release credits=4, and a new packet on channel 1 sends cleanly.
- SERIALIZATION_FACTOR=1, NUM_CHANNELS=1 -> one flit per beat with back-to-back throughput of 1 beat per cycle.
